// File: rtl/mqueue_remote_pkg.sv
// mqueue_remote_pkg: shared bus types, register map and FSM encodings for the remote mqueue bridge
package mqueue_remote_pkg;
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
  } t_wishbone_slave_in;
  typedef t_wishbone_slave_in t_wishbone_master_out;
  typedef struct packed {
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;
    logic [31:0] dat;
  } t_wishbone_slave_out;
  typedef t_wishbone_slave_out t_wishbone_master_in;
  localparam logic [31:0] c_SI_DATA_BASE = 32'h0000_1000;
  localparam logic [3:0] c_SI_COMMAND = 4'h0;
  localparam logic [3:0] c_SI_STATUS = 4'h4;
  localparam int c_CMD_CLAIM = 24;
  localparam int c_CMD_READY = 25;
  localparam int c_CMD_DISCARD = 26;
  localparam logic [31:0] c_EBM_FLUSH = 32'h04;
  localparam logic [31:0] c_EBM_DST_MAC_HI = 32'h1c;
  localparam logic [31:0] c_EBM_DST_MAC_LO = 32'h20;
  localparam logic [31:0] c_EBM_DST_IPV4 = 32'h24;
  localparam logic [31:0] c_EBM_DST_UDP_PORT = 32'h28;
  typedef enum logic [2:0] {S_IDLE, S_MAC_HI, S_MAC_LO, S_IP, S_PORT, S_DATA, S_FLUSH, S_DONE} t_state;
  typedef enum logic [1:0] {P_PREP, P_LOAD, P_REQ, P_WAIT} t_phase;
endpackage

// File: rtl/mqueue_remote_slot_ram.sv
// mqueue_remote_slot_ram: simple dual-port slot buffer RAM with registered reads
module mqueue_remote_slot_ram #(
  parameter int g_depth = 128,
  parameter int aw = 7
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [aw-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic [aw-1:0] b_addr,
  output logic [31:0]   b_rdata
);
  logic [31:0] mem [g_depth];
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end
endmodule

// File: rtl/mqueue_remote_eb_bridge.sv
// mqueue_remote_eb_bridge: outbound message slots drained round-robin into an Etherbone master
module mqueue_remote_eb_bridge
  import mqueue_remote_pkg::*;
#(
  parameter int          g_slots = 2,
  parameter int          g_slot_words = 64,
  parameter logic [31:0] g_ebm_data_base = 32'h8000_0000,
  parameter int          g_timeout = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  t_wishbone_slave_in   si_slave_i,
  output t_wishbone_slave_out  si_slave_o,
  output t_wishbone_master_out ebm_master_o,
  input  t_wishbone_master_in  ebm_master_i
);
  localparam int sw = g_slots > 1 ? $clog2(g_slots) : 1;
  localparam int cw = $clog2(g_slot_words) + 1;
  localparam int aw = $clog2(g_slots * g_slot_words);
  localparam int tw = $clog2(g_timeout + 1);
  logic req, ctl_hit, buf_hit, buf_we, si_ack, buf_rd, pick_ok, done, fail, cyc, stb;
  logic [7:0] ctl_slot;
  logic [3:0] buf_slot;
  logic [5:0] word;
  logic [sw-1:0] cs, bs, pick, cur, rr;
  logic [aw-1:0] a_addr, b_addr;
  logic [31:0] a_q, ram_q, si_dat, base, adr, dat, ld_adr, ld_dat;
  logic [g_slots-1:0] busy;
  logic [cw-1:0] cnt [g_slots];
  logic [cw-1:0] k, widx, last_k;
  logic [tw-1:0] timer;
  t_state state, state_d;
  t_phase phase;
  logic unused;
  assign unused = ^{si_slave_i.sel, ebm_master_i.rty, ebm_master_i.dat};
  assign req = si_slave_i.cyc & si_slave_i.stb;
  assign ctl_slot = si_slave_i.adr[11:4];
  assign buf_slot = si_slave_i.adr[11:8];
  assign word = si_slave_i.adr[7:2];
  assign cs = sw'(ctl_slot);
  assign bs = sw'(buf_slot);
  assign ctl_hit = req && si_slave_i.adr[31:12] == 20'd0 && int'(ctl_slot) < g_slots;
  assign buf_hit = req && (si_slave_i.adr & 32'hffff_f000) == c_SI_DATA_BASE && int'(buf_slot) < g_slots && int'(word) < g_slot_words;
  assign buf_we = buf_hit && si_slave_i.we && !busy[bs];
  assign a_addr = aw'(int'(bs) * g_slot_words + int'(word));
  assign b_addr = aw'(int'(cur) * g_slot_words + int'(widx));
  assign si_slave_o.ack = si_ack;
  assign si_slave_o.err = 1'b0;
  assign si_slave_o.rty = 1'b0;
  assign si_slave_o.stall = 1'b0;
  assign si_slave_o.dat = buf_rd ? a_q : si_dat;
  assign ebm_master_o.cyc = cyc;
  assign ebm_master_o.stb = stb;
  assign ebm_master_o.we = cyc;
  assign ebm_master_o.sel = {4{cyc}};
  assign ebm_master_o.adr = adr;
  assign ebm_master_o.dat = dat;
  mqueue_remote_slot_ram #(.g_depth(g_slots * g_slot_words), .aw(aw)) ram (
    .clk(clk_i), .a_we(buf_we), .a_addr(a_addr), .a_wdata(si_slave_i.dat), .a_rdata(a_q),
    .b_addr(b_addr), .b_rdata(ram_q)
  );
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy <= '0;
      for (int i = 0; i < g_slots; i++) cnt[i] <= '0;
      si_ack <= 1'b0;
      buf_rd <= 1'b0;
      si_dat <= '0;
    end else begin
      si_ack <= req;
      buf_rd <= buf_hit & !si_slave_i.we;
      si_dat <= ctl_hit && si_slave_i.adr[3:0] == c_SI_STATUS ? {16'h0, 8'(cnt[cs]), 7'h0, busy[cs]} : '0;
      if (buf_we && cw'(word) >= cnt[bs]) cnt[bs] <= cw'(word) + 1'b1;
      if (ctl_hit && si_slave_i.we && si_slave_i.adr[3:0] == c_SI_COMMAND) begin
        if (si_slave_i.dat[c_CMD_CLAIM] && !busy[cs]) cnt[cs] <= '0;
        if (si_slave_i.dat[c_CMD_READY] && !busy[cs] && cnt[cs] >= cw'(4)) busy[cs] <= 1'b1;
        if (si_slave_i.dat[c_CMD_DISCARD] && !(state != S_IDLE && cur == cs)) begin
          busy[cs] <= 1'b0;
          cnt[cs] <= '0;
        end
      end
      if (state == S_DONE) busy[cur] <= 1'b0;
    end
  end
  always_comb begin
    pick = rr;
    pick_ok = 1'b0;
    for (int j = g_slots; j >= 1; j--)
      if (busy[sw'((int'(rr) + j) % g_slots)]) begin
        pick = sw'((int'(rr) + j) % g_slots);
        pick_ok = 1'b1;
      end
  end
  assign done = cyc & ebm_master_i.ack;
  assign fail = cyc & (ebm_master_i.err | timer == tw'(g_timeout - 1));
  assign last_k = cnt[cur] - cw'(4);
  always_comb begin
    state_d = state == S_IDLE ? (pick_ok ? S_MAC_HI : S_IDLE) :
              state == S_DONE ? S_IDLE :
              fail ? S_DONE :
              done ? (state == S_DATA && k != last_k ? S_DATA : t_state'(state + 3'd1)) : state;
    widx = state == S_MAC_HI ? cw'(2) : state == S_IP ? cw'(0) : state == S_PORT ? cw'(1) : k + cw'(3);
    ld_adr = state == S_MAC_HI ? c_EBM_DST_MAC_HI :
             state == S_MAC_LO ? c_EBM_DST_MAC_LO :
             state == S_IP ? c_EBM_DST_IPV4 :
             state == S_PORT ? c_EBM_DST_UDP_PORT :
             state == S_DATA ? g_ebm_data_base | (base + 32'({k, 2'b00})) : c_EBM_FLUSH;
    ld_dat = state == S_MAC_HI ? 32'hffff_ffff :
             state == S_MAC_LO ? 32'h0000_ffff :
             state == S_PORT ? {16'h0, ram_q[15:0]} :
             state == S_FLUSH ? 32'h1 : ram_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
      phase <= P_PREP;
      cur <= '0;
      rr <= '0;
      k <= '0;
      base <= '0;
      timer <= '0;
      cyc <= 1'b0;
      stb <= 1'b0;
      adr <= '0;
      dat <= '0;
    end else begin
      state <= state_d;
      timer <= cyc ? timer + 1'b1 : '0;
      if (state == S_IDLE && pick_ok) begin
        cur <= pick;
        rr <= pick;
        k <= '0;
      end
      if (state == S_DATA && done && !fail) k <= k + 1'b1;
      if (state == S_MAC_HI && phase == P_LOAD) base <= ram_q;
      if (state == S_IDLE || state == S_DONE) phase <= P_PREP;
      else if (phase == P_PREP) phase <= P_LOAD;
      else if (phase == P_LOAD) begin
        phase <= P_REQ;
        cyc <= 1'b1;
        stb <= 1'b1;
        adr <= ld_adr;
        dat <= ld_dat;
      end else if (phase == P_REQ && !ebm_master_i.stall) begin
        stb <= 1'b0;
        phase <= P_WAIT;
      end
      if (done | fail) begin
        cyc <= 1'b0;
        stb <= 1'b0;
        phase <= P_PREP;
      end
    end
  end
endmodule

// File: tb/tb_mqueue_remote_eb_bridge.sv
// tb_mqueue_remote_eb_bridge: directed self-checking bench with an Etherbone slave responder
module tb_mqueue_remote_eb_bridge;
  import mqueue_remote_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  t_wishbone_slave_in si_i;
  t_wishbone_slave_out si_o;
  t_wishbone_master_out ebm_o;
  t_wishbone_master_in ebm_i;
  int n_chk = 0, n_pass = 0;
  int stall_cfg = 0, stall_left = 0, viol = 0, ack_idx = 0, err_at = -1;
  logic pend = 1'b0, in_req = 1'b0, last_ack = 1'b0;
  logic [31:0] h_adr, h_dat, rd;
  logic [31:0] log_adr[$], log_dat[$], exp_adr[$], exp_dat[$];
  always #5 clk = ~clk;
  mqueue_remote_eb_bridge dut (
    .clk_i(clk), .rst_n_i(rst_n), .si_slave_i(si_i), .si_slave_o(si_o),
    .ebm_master_o(ebm_o), .ebm_master_i(ebm_i)
  );
  always @(negedge clk) begin
    ebm_i = '0;
    if (!rst_n) begin
      pend = 1'b0;
      in_req = 1'b0;
    end else begin
      if (pend) begin
        if (ack_idx == err_at) ebm_i.err = 1'b1;
        else ebm_i.ack = 1'b1;
        ack_idx++;
        pend = 1'b0;
      end
      if (ebm_o.cyc && ebm_o.stb) begin
        if (!in_req) begin
          in_req = 1'b1;
          stall_left = stall_cfg;
          h_adr = ebm_o.adr;
          h_dat = ebm_o.dat;
        end else if (ebm_o.adr !== h_adr || ebm_o.dat !== h_dat || ebm_o.we !== 1'b1 || ebm_o.sel !== 4'hf) viol++;
        if (stall_left > 0) begin
          ebm_i.stall = 1'b1;
          stall_left--;
        end else begin
          log_adr.push_back(ebm_o.adr);
          log_dat.push_back(ebm_o.dat);
          pend = 1'b1;
          in_req = 1'b0;
        end
      end else if (in_req) begin
        viol++;
        in_req = 1'b0;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic si_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    si_i.cyc = 1'b1; si_i.stb = 1'b1; si_i.we = 1'b1; si_i.sel = 4'hf; si_i.adr = a; si_i.dat = d;
    @(negedge clk);
    si_i.cyc = 1'b0; si_i.stb = 1'b0; si_i.we = 1'b0;
  endtask
  task automatic si_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    si_i.cyc = 1'b1; si_i.stb = 1'b1; si_i.we = 1'b0; si_i.sel = 4'hf; si_i.adr = a;
    @(negedge clk);
    d = si_o.dat;
    last_ack = si_o.ack;
    si_i.cyc = 1'b0; si_i.stb = 1'b0;
  endtask
  task automatic fill(input int s, input logic [31:0] ip, input logic [31:0] port, input logic [31:0] base,
                      input int n, input logic [31:0] first);
    logic [31:0] a;
    a = 32'h1000 + 32'(s) * 32'h100;
    si_wr(32'(s * 16), 32'h0100_0000);
    si_wr(a, ip);
    si_wr(a + 32'd4, port);
    si_wr(a + 32'd8, base);
    for (int i = 0; i < n; i++) si_wr(a + 32'd12 + 32'(4 * i), first + 32'(i));
  endtask
  task automatic exp_msg(input logic [31:0] ip, input logic [31:0] port, input logic [31:0] base,
                         input int n, input logic [31:0] first);
    exp_adr.push_back(32'h1c); exp_dat.push_back(32'hffff_ffff);
    exp_adr.push_back(32'h20); exp_dat.push_back(32'h0000_ffff);
    exp_adr.push_back(32'h24); exp_dat.push_back(ip);
    exp_adr.push_back(32'h28); exp_dat.push_back({16'h0, port[15:0]});
    for (int i = 0; i < n; i++) begin
      exp_adr.push_back(32'h8000_0000 | (base + 32'(4 * i)));
      exp_dat.push_back(first + 32'(i));
    end
    exp_adr.push_back(32'h04); exp_dat.push_back(32'h1);
  endtask
  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(log_adr.size()), 32'(exp_adr.size()));
    for (int i = 0; i < exp_adr.size(); i++) begin
      chk($sformatf("%s_adr%0d", tag, i), i < log_adr.size() ? log_adr[i] : 32'hx, exp_adr[i]);
      chk($sformatf("%s_dat%0d", tag, i), i < log_dat.size() ? log_dat[i] : 32'hx, exp_dat[i]);
    end
    log_adr.delete(); log_dat.delete(); exp_adr.delete(); exp_dat.delete();
  endtask
  task automatic wait_free(input int s, input string tag);
    logic [31:0] v;
    v = 32'h1;
    for (int i = 0; i < 400 && v[0]; i++) si_rd(32'(s * 16 + 4), v);
    chk(tag, 32'(v[0]), 32'h0);
  endtask
  initial begin
    si_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(ebm_o.cyc), 32'h0);
    chk("rst_stb", 32'(ebm_o.stb), 32'h0);
    chk("rst_we", 32'(ebm_o.we), 32'h0);
    chk("rst_si_ack", 32'(si_o.ack), 32'h0);
    rst_n = 1'b1;
    si_rd(32'h4, rd); chk("rst_status0", rd, 32'h0);
    chk("si_ack", 32'(last_ack), 32'h1);
    si_rd(32'h14, rd); chk("rst_status1", rd, 32'h0);
    fill(0, 32'hffff_ffff, 32'hebd0, 32'h0012_0000, 2, 32'd4);
    si_rd(32'h4, rd); chk("basic_count", rd, 32'h0500);
    si_rd(32'h100c, rd); chk("basic_bufrd", rd, 32'h4);
    si_wr(32'h0, 32'h0200_0000);
    si_rd(32'h4, rd); chk("basic_busy", rd, 32'h0501);
    wait_free(0, "basic_free");
    exp_adr = '{32'h1c, 32'h20, 32'h24, 32'h28, 32'h8012_0000, 32'h8012_0004, 32'h04};
    exp_dat = '{32'hffff_ffff, 32'h0000_ffff, 32'hffff_ffff, 32'h0000_ebd0, 32'h4, 32'h5, 32'h1};
    check_log("basic");
    si_rd(32'h4, rd); chk("basic_status_after", rd, 32'h0500);
    fill(0, 32'hffff_ffff, 32'hebd0, 32'h0014_0000, 5, 32'd1);
    si_rd(32'h4, rd); chk("long_count", rd, 32'h0800);
    si_wr(32'h0, 32'h0200_0000);
    wait_free(0, "long_free");
    exp_msg(32'hffff_ffff, 32'hebd0, 32'h0014_0000, 5, 32'd1);
    check_log("long");
    fill(1, 32'hc0a8_0001, 32'h0001_1234, 32'h0020_0000, 3, 32'h10);
    stall_cfg = 5;
    viol = 0;
    si_wr(32'h10, 32'h0200_0000);
    wait_free(1, "stall_free");
    stall_cfg = 0;
    exp_msg(32'hc0a8_0001, 32'h1234, 32'h0020_0000, 3, 32'h10);
    check_log("stall");
    chk("stall_stable", 32'(viol), 32'h0);
    fill(0, 32'h0a00_0001, 32'h5555, 32'h0030_0000, 0, 32'h0);
    si_wr(32'h0, 32'h0200_0000);
    si_rd(32'h4, rd); chk("short_status", rd, 32'h0300);
    repeat (20) @(negedge clk);
    chk("short_no_ebm", 32'(log_adr.size()), 32'h0);
    fill(1, 32'h1, 32'h2, 32'h3, 1, 32'h5);
    si_wr(32'h10, 32'h0400_0000);
    si_rd(32'h14, rd); chk("discard_status", rd, 32'h0);
    fill(0, 32'h0a00_0002, 32'h0101, 32'h0030_0000, 2, 32'ha0);
    fill(1, 32'h0a00_0003, 32'h0202, 32'h0040_0000, 3, 32'hb0);
    si_wr(32'h0, 32'h0200_0000);
    si_wr(32'h10, 32'h0200_0000);
    wait_free(0, "two_free0");
    wait_free(1, "two_free1");
    exp_msg(32'h0a00_0002, 32'h0101, 32'h0030_0000, 2, 32'ha0);
    exp_msg(32'h0a00_0003, 32'h0202, 32'h0040_0000, 3, 32'hb0);
    check_log("two");
    fill(0, 32'h0a00_0004, 32'h0303, 32'h0050_0000, 2, 32'h7);
    err_at = ack_idx + 4;
    si_wr(32'h0, 32'h0200_0000);
    wait_free(0, "err_free");
    err_at = -1;
    exp_msg(32'h0a00_0004, 32'h0303, 32'h0050_0000, 2, 32'h7);
    void'(exp_adr.pop_back()); void'(exp_dat.pop_back());
    void'(exp_adr.pop_back()); void'(exp_dat.pop_back());
    check_log("err");
    fill(0, 32'h0a00_0005, 32'h0404, 32'h0060_0000, 2, 32'h9);
    si_wr(32'h0, 32'h0200_0000);
    wait_free(0, "after_err_free");
    exp_msg(32'h0a00_0005, 32'h0404, 32'h0060_0000, 2, 32'h9);
    check_log("after_err");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
